add_mul_result_acc: RTL
=======================

Name: add_mul_result_acc

Overview:
- Sequential stage directly downstream of the 4-bit add/multiply datapath.
- Captures each 8-bit result with its operation tag through a valid/ready handshake and accumulates a burst of results into a wide unsigned sum.
- Emits the burst total, beat count and overflow status on a held output handshake.
- Consumers use it to build multiply-accumulate and sum-of-sums sequences without touching the combinational unit.

Parameters:
- ACC_W, 16, accumulator and output sum width; legal range 9..32.
- CNT_W, 4, beat-counter width; maximum burst length 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_op  input  1  operation tag of the result: 1 = multiply, 0 = add.
- in_res  input  8  datapath result; in_res[i] is driven by Result_(7-i)_, so in_res[0] is the LSB.
- cfg_len  input  CNT_W  beats per burst; 0 encodes 2^CNT_W; sampled on the first beat of a burst.
- flush  input  1  close the current burst early.
- out_valid  output  1  burst total available.
- out_ready  input  1  downstream accepts the total.
- out_acc  output  ACC_W  burst sum.
- out_cnt  output  CNT_W+1  beats in the burst.
- out_nmul  output  CNT_W+1  multiply-tagged beats in the burst.
- out_ovf  output  1  sticky: the sum exceeded 2^ACC_W-1 during the burst.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state IDLE; acc, cnt, nmul, ovf and len_q cleared.
  - out_valid=0, out_acc=0, out_cnt=0, out_nmul=0, out_ovf=0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-burst or in HOLD discards the partial or pending result; nothing is emitted.
- States:
  - IDLE: no beats held.
  - ACCUM: one or more beats held.
  - HOLD: total presented on the output.
- in_ready = rst_n & (state != HOLD). A beat transfers when in_valid & in_ready.
- Operand extension:
  - in_op=1: addend = zero-extend(in_res[7:0]).
  - in_op=0: addend = zero-extend(in_res[3:0]); in_res[7:4] is ignored.
- On each accepted beat:
  - acc <= acc + addend, computed at ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets ovf. Default sum wraps modulo 2^ACC_W.
  - cnt increments; nmul increments when in_op=1.
- IDLE + beat:
  - len_q <= cfg_len.
  - acc starts from 0 plus the addend.
  - Go to ACCUM, or go directly to HOLD if len_q equals 1 or flush=1.
- ACCUM + beat: if the new cnt equals the effective length (len_q, with 0 meaning 2^CNT_W) or flush=1, go to HOLD.
- ACCUM + flush with no beat: go to HOLD with the current totals.
- IDLE + flush with no beat: ignored; empty bursts are never emitted.
- Flush and a beat in the same cycle: the beat is included, then the burst closes.
- Latency: out_valid rises on the cycle after the closing beat or flush edge.
- HOLD:
  - out_* registered and stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid <= 0; acc, cnt, nmul and ovf are cleared; go to IDLE.
  - in_ready returns high on the next cycle, giving one bubble per burst.
  - flush and in_valid are ignored.
- cfg_len changes mid-burst have no effect until the next burst.
- Maximum burst sum: 16 x 225 = 3600, which fits the default ACC_W with no overflow.

Optional Feature:
- Macro ADD_MUL_ACC_SAT_EN.
- Defined:
  - On overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst.
  - ovf is still set.
- Undefined: wrap modulo 2^ACC_W; ovf set on the first carry-out.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0 and all outputs 0. Release -> in_ready=1, out_valid=0.
- Mixed burst, cfg_len=3: beats mul 0xE1, add 0xF7, mul 0x06 -> next cycle out_acc=0x00EE, out_cnt=3, out_nmul=2, out_ovf=0. out_ready=1 -> in_ready high after 1 bubble.
- Early flush, cfg_len=0 (16): beats add 0x05 and 0x0A, then flush alone -> out_acc=0x000F, out_cnt=2, out_nmul=0. A flush asserted in IDLE produces no output.
- Backpressure: complete a 1-beat burst (mul 0x40) and hold out_ready=0 for 5 cycles -> out_acc=0x0040 stays stable and in_ready=0 throughout. in_valid pulses during HOLD are not absorbed.
- Overflow, ACC_W=9, cfg_len=3: mul 0xFF three times -> without the macro, out_acc=0x0FD and out_ovf=1. With ADD_MUL_ACC_SAT_EN, out_acc=0x1FF and out_ovf=1.
- Reset mid-burst: after 2 accepted beats, pulse rst_n=0 for 1 cycle -> no out_valid. A following cfg_len=1 burst with add 0x03 yields out_acc=3, out_cnt=1.

Source files
------------

// File: rtl/add_mul_result_acc_if.sv
// ---------------------------------------------------------------------------
// add_mul_result_acc_if
// Bundles the input handshake (result beat, configuration, flush) and the
// output handshake (burst total) of the add/multiply result accumulator.
// master: the side that produces beats and consumes totals.
// slave : the accumulator itself.
// ---------------------------------------------------------------------------
interface add_mul_result_acc_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  // Input side: one 8-bit datapath result per beat
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [7:0]       in_res;
  logic [CNT_W-1:0] cfg_len;
  logic             flush;

  // Output side: burst total held until accepted
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W:0]   out_cnt;
  logic [CNT_W:0]   out_nmul;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_op,
    output in_res,
    output cfg_len,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_cnt,
    input  out_nmul,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_res,
    input  cfg_len,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_cnt,
    output out_nmul,
    output out_ovf
  );
endinterface

// File: rtl/add_mul_result_acc.sv
// ---------------------------------------------------------------------------
// add_mul_result_acc
// Accumulates a burst of 8-bit add/multiply results into an ACC_W-bit
// unsigned sum and presents the total, beat count, multiply-beat count and a
// sticky overflow flag on a held output handshake.
//
// Burst length comes from cfg_len on the first beat (0 means 2^CNT_W); flush
// closes a burst early. A closed burst sits in HOLD until out_ready, during
// which no beats are accepted (one bubble per burst).
//
// Optional build macro ADD_MUL_ACC_SAT_EN: when defined the sum saturates at
// 2^ACC_W-1 on overflow instead of wrapping; ovf is set either way.
//
// Reset is synchronous and active low.
// ---------------------------------------------------------------------------
module add_mul_result_acc #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  add_mul_result_acc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Add an addend to the running sum one bit wider than the accumulator.
  // Bit ACC_W of the result is the carry-out used to flag overflow. In the
  // saturating build a carry clamps the sum to all-ones; since any further
  // non-zero addend carries again, the clamp persists for the whole burst.
  function automatic logic [ACC_W:0] acc_add(
    input logic [ACC_W-1:0] base,
    input logic [ACC_W-1:0] addend
  );
    logic [ACC_W:0] sum;
    sum = {1'b0, base} + {1'b0, addend};
`ifdef ADD_MUL_ACC_SAT_EN
    if (sum[ACC_W]) begin
      sum = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sum = sum;
    end
`endif
    return sum;
  endfunction

  // Effective burst length: a zero length field encodes the maximum 2^CNT_W.
  function automatic logic [CNT_W:0] eff_len(input logic [CNT_W-1:0] len);
    logic [CNT_W:0] res;
    if (len == {CNT_W{1'b0}}) begin
      res = {1'b1, {CNT_W{1'b0}}};
    end else begin
      res = {1'b0, len};
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W:0]   cnt_q,   cnt_d;
  logic [CNT_W:0]   nmul_q,  nmul_d;
  logic             ovf_q,   ovf_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s;
  logic             beat_s;
  logic [ACC_W-1:0] addend_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic [CNT_W:0]   nmul_inc_s;
  logic             close_s;

  // Accept beats whenever out of reset and not presenting a total.
  assign in_ready_s = rst_n & (state_q != S_HOLD);
  assign beat_s     = bus.in_valid & in_ready_s;

  // Multiply results use all eight bits; add results only the low nibble.
  assign addend_s = bus.in_op ? {{(ACC_W-8){1'b0}}, bus.in_res}
                              : {{(ACC_W-4){1'b0}}, bus.in_res[3:0]};

  // Counter updates shared by the IDLE and ACCUM beat paths.
  assign cnt_inc_s  = cnt_q + {{CNT_W{1'b0}}, 1'b1};
  assign nmul_inc_s = nmul_q + {{CNT_W{1'b0}}, bus.in_op};

  // Next-state and datapath update for the burst FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    nmul_d      = nmul_q;
    ovf_d       = ovf_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    sum_s       = {(ACC_W+1){1'b0}};
    close_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A lone flush here is ignored: empty bursts are never emitted.
        if (beat_s) begin
          sum_s   = acc_add({ACC_W{1'b0}}, addend_s);
          len_d   = bus.cfg_len;
          acc_d   = sum_s[ACC_W-1:0];
          ovf_d   = sum_s[ACC_W];
          cnt_d   = {{CNT_W{1'b0}}, 1'b1};
          nmul_d  = {{CNT_W{1'b0}}, bus.in_op};
          close_s = (bus.cfg_len == CNT_W'(1)) | bus.flush;
          if (close_s) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCUM: begin
        if (beat_s) begin
          // Length was latched on the first beat; cfg_len is ignored here.
          sum_s   = acc_add(acc_q, addend_s);
          acc_d   = sum_s[ACC_W-1:0];
          ovf_d   = ovf_q | sum_s[ACC_W];
          cnt_d   = cnt_inc_s;
          nmul_d  = nmul_inc_s;
          close_s = (cnt_inc_s == eff_len(len_q)) | bus.flush;
        end else begin
          close_s = bus.flush;
        end
        if (close_s) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_ACCUM;
        end
      end

      S_HOLD: begin
        // Totals stay frozen until the consumer takes them.
        if (out_valid_q & bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {(CNT_W+1){1'b0}};
          nmul_d      = {(CNT_W+1){1'b0}};
          ovf_d       = 1'b0;
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = {(CNT_W+1){1'b0}};
        nmul_d      = {(CNT_W+1){1'b0}};
        ovf_d       = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or held burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {(CNT_W+1){1'b0}};
      nmul_q      <= {(CNT_W+1){1'b0}};
      ovf_q       <= 1'b0;
      len_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      nmul_q      <= nmul_d;
      ovf_q       <= ovf_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output totals come straight from the registers, so they are stable in HOLD.
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_nmul  = nmul_q;
  assign bus.out_ovf   = ovf_q;

endmodule
